// File: rtl/spi_image_loader.sv
// rtl/spi_image_loader.sv - SPI byte-stream command decoder and image buffer loader
//
// Purpose: takes bytes from the SPI receiver one at a time and decodes a
// one-byte command. LOAD copies IMG_BYTES bytes of packed binary image into
// the image buffer. CLEAR zero-fills the buffer. Once a full image is
// resident, img_ready is raised and SPI traffic is held off until the
// inference core returns img_consumed.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   spi_rx_data[7:0]      received byte from the SPI peripheral
//   byte_valid            peripheral holds a complete byte
//   byte_taken            one-cycle acknowledge back to the peripheral
//   rx_enable             permits the peripheral to receive
//   buf_we/addr/wdata     image buffer write port
//   img_ready             full image resident in the buffer
//   img_consumed          inference is done with the image (pulse or level)
//   cmd_error             one-cycle pulse on unknown command or LOAD timeout
//   busy                  controller is in any state other than CMD_WAIT
module spi_image_loader #(
  parameter int         IMG_BYTES      = 128,
  parameter int         ADDR_W         = 7,
  parameter logic [7:0] CMD_LOAD       = 8'hA0,
  parameter logic [7:0] CMD_CLEAR      = 8'hC0,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        spi_rx_data,
  input  logic              byte_valid,
  output logic              byte_taken,
  output logic              rx_enable,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  output logic              img_ready,
  input  logic              img_consumed,
  output logic              cmd_error,
  output logic              busy
);

  localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [TMO_W-1:0]  TMO_ZERO  = '0;
  localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    CMD_WAIT,
    LOAD,
    CLEAR,
    IMG_READY
  } state_t;

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              byte_taken_q, byte_taken_d;
  logic              rx_enable_q, rx_enable_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_wdata_q, buf_wdata_d;
  logic              img_ready_q, img_ready_d;
  logic              cmd_error_q, cmd_error_d;
  logic              busy_q, busy_d;
  logic              accept;

  // The peripheral's byte_valid is registered and may stay high one cycle
  // after our acknowledge; armed blocks a second accept of the same byte
  // until byte_valid has been seen low.
  assign accept = byte_valid && armed_q && ((state_q == CMD_WAIT) || (state_q == LOAD));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= CMD_WAIT;
      armed_q      <= 1'b1;
      cnt_q        <= ADDR_ZERO;
      tmo_q        <= TMO_ZERO;
      byte_taken_q <= 1'b0;
      rx_enable_q  <= 1'b0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= ADDR_ZERO;
      buf_wdata_q  <= 8'h00;
      img_ready_q  <= 1'b0;
      cmd_error_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      byte_taken_q <= byte_taken_d;
      rx_enable_q  <= rx_enable_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      img_ready_q  <= img_ready_d;
      cmd_error_q  <= cmd_error_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    byte_taken_d = accept;
    armed_d      = armed_q ? !accept : !byte_valid;
    buf_we_d     = 1'b0;
    buf_addr_d   = buf_addr_q;
    buf_wdata_d  = buf_wdata_q;
    cmd_error_d  = 1'b0;

    case (state_q)
      CMD_WAIT: begin
        if (accept) begin
          if (spi_rx_data == CMD_LOAD) begin
            state_d = LOAD;
            cnt_d   = ADDR_ZERO;
            tmo_d   = TMO_ZERO;
          end else if (spi_rx_data == CMD_CLEAR) begin
            // First zero write is issued together with the command accept so
            // that every cycle spent in CLEAR carries exactly one write.
            state_d     = CLEAR;
            cnt_d       = ADDR_ZERO;
            buf_we_d    = 1'b1;
            buf_addr_d  = ADDR_ZERO;
            buf_wdata_d = 8'h00;
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (accept) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = cnt_q;
          buf_wdata_d = spi_rx_data;
          tmo_d       = TMO_ZERO;
          if (cnt_q == LAST_ADDR) begin
            state_d = IMG_READY;
          end else begin
            cnt_d = cnt_q + ADDR_ONE;
          end
        end else if ((tmo_q + TMO_ONE) == TMO_LIMIT) begin
          // Stalled sender: abandon the partial image, buffer left as-is.
          cmd_error_d = 1'b1;
          state_d     = CMD_WAIT;
          tmo_d       = TMO_ZERO;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      CLEAR: begin
        // cnt_q holds the address most recently written.
        if (cnt_q == LAST_ADDR) begin
          state_d = CMD_WAIT;
        end else begin
          cnt_d       = cnt_q + ADDR_ONE;
          buf_we_d    = 1'b1;
          buf_addr_d  = cnt_q + ADDR_ONE;
          buf_wdata_d = 8'h00;
        end
      end

      IMG_READY: begin
        if (img_consumed) begin
          state_d = CMD_WAIT;
        end
      end

      default: begin
        state_d = CMD_WAIT;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state the controller is actually in.
    rx_enable_d = (state_d == CMD_WAIT) || (state_d == LOAD);
    img_ready_d = (state_d == IMG_READY);
    busy_d      = (state_d != CMD_WAIT);
  end

  assign byte_taken = byte_taken_q;
  assign rx_enable  = rx_enable_q;
  assign buf_we     = buf_we_q;
  assign buf_addr   = buf_addr_q;
  assign buf_wdata  = buf_wdata_q;
  assign img_ready  = img_ready_q;
  assign cmd_error  = cmd_error_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_image_loader.sv
// tb/tb_spi_image_loader.sv - self-checking bench for spi_image_loader
module tb_spi_image_loader;

  localparam int ADDR_W    = 7;
  localparam int IMG_BYTES = 128;
  localparam int TMO       = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        spi_rx_data;
  logic              byte_valid;
  logic              byte_taken;
  logic              rx_enable;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_wdata;
  logic              img_ready;
  logic              img_consumed;
  logic              cmd_error;
  logic              busy;

  always #5 clk = ~clk;

  spi_image_loader #(
    .IMG_BYTES(IMG_BYTES),
    .ADDR_W(ADDR_W),
    .CMD_LOAD(8'hA0),
    .CMD_CLEAR(8'hC0),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_rx_data(spi_rx_data),
    .byte_valid(byte_valid),
    .byte_taken(byte_taken),
    .rx_enable(rx_enable),
    .buf_we(buf_we),
    .buf_addr(buf_addr),
    .buf_wdata(buf_wdata),
    .img_ready(img_ready),
    .img_consumed(img_consumed),
    .cmd_error(cmd_error),
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int taken_cnt = 0;
  int err_cnt = 0;
  int wr_cnt = 0;
  int err_cyc = -1;
  logic [15:0] exp_q[$];
  logic [15:0] exp_e;

  // Values seen right after the accepting edge of the last send_byte.
  logic tk_taken, tk_err, tk_ready, tk_rxen, tk_busy;
  int   tk_cyc;

  // Advance one clock and sample 1 time unit after the edge; the write
  // scoreboard is popped here whenever the DUT strobes buf_we.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (byte_taken === 1'b1) taken_cnt++;
    if (cmd_error === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (buf_we === 1'b1) begin
      wr_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got addr %0d data %02h, none expected", buf_addr, buf_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({1'b0, buf_addr, buf_wdata} !== exp_e) begin
          fails++;
          $display("FAIL wr_data: got addr %0d data %02h, expected addr %0d data %02h",
                   buf_addr, buf_wdata, exp_e[14:8], exp_e[7:0]);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_rx_data = b;
    byte_valid  = 1'b1;
    tick();
    tk_taken = byte_taken;
    tk_err   = cmd_error;
    tk_ready = img_ready;
    tk_rxen  = rx_enable;
    tk_busy  = busy;
    tk_cyc   = cyc;
    tick();
    byte_valid = 1'b0;
    tick();
  endtask

  task automatic push_wr(input int addr, input logic [7:0] data);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(addr);
    exp_q.push_back({1'b0, a, data});
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    byte_valid   = 1'b0;
    img_consumed = 1'b0;
    spi_rx_data  = 8'h00;
    repeat (3) tick();
    tests++;
    if ({byte_taken, rx_enable, buf_we, img_ready, cmd_error, busy, buf_addr, buf_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got tk=%b rx=%b we=%b rdy=%b err=%b busy=%b addr=%0d wd=%02h, expected all 0",
               byte_taken, rx_enable, buf_we, img_ready, cmd_error, busy, buf_addr, buf_wdata);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (rx_enable !== 1'b1 || busy !== 1'b0 || img_ready !== 1'b0 || buf_we !== 1'b0 || cmd_error !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got rx=%b busy=%b rdy=%b we=%b err=%b, expected rx=1 others 0",
               rx_enable, busy, img_ready, buf_we, cmd_error);
    end
  endtask

  task automatic test_full_load(input logic [7:0] base);
    int   t0;
    int   w0;
    logic ready_prev;
    t0 = taken_cnt;
    w0 = wr_cnt;
    ready_prev = 1'b0;
    send_byte(8'hA0);
    tests++;
    if (tk_taken !== 1'b1 || busy !== 1'b1 || rx_enable !== 1'b1) begin
      fails++;
      $display("FAIL load_cmd[%02h]: got taken=%b busy=%b rx=%b, expected 1 1 1", base, tk_taken, busy, rx_enable);
    end
    for (int k = 0; k < IMG_BYTES; k++) begin
      push_wr(k, 8'(k) + base);
      send_byte(8'(k) + base);
      if (k == IMG_BYTES - 2) ready_prev = tk_ready;
    end
    tests++;
    if (taken_cnt - t0 != IMG_BYTES + 1) begin
      fails++;
      $display("FAIL load_taken_cnt[%02h]: got %0d, expected %0d", base, taken_cnt - t0, IMG_BYTES + 1);
    end
    tests++;
    if (wr_cnt - w0 != IMG_BYTES || exp_q.size() != 0) begin
      fails++;
      $display("FAIL load_wr_cnt[%02h]: got %0d writes, %0d pending, expected %0d and 0",
               base, wr_cnt - w0, exp_q.size(), IMG_BYTES);
    end
    tests++;
    if (tk_ready !== 1'b1 || tk_taken !== 1'b1 || ready_prev !== 1'b0 || tk_rxen !== 1'b0) begin
      fails++;
      $display("FAIL load_ready_timing[%02h]: got rdy=%b taken=%b rdy_prev=%b rx=%b, expected 1 1 0 0",
               base, tk_ready, tk_taken, ready_prev, tk_rxen);
    end
    tests++;
    if (img_ready !== 1'b1 || rx_enable !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL load_hold[%02h]: got rdy=%b rx=%b busy=%b, expected 1 0 1", base, img_ready, rx_enable, busy);
    end
  endtask

  task automatic test_consume_reload();
    int t0;
    t0 = taken_cnt;
    spi_rx_data = 8'hA0;
    byte_valid  = 1'b1;
    repeat (4) tick();
    byte_valid = 1'b0;
    tick();
    tests++;
    if (taken_cnt != t0 || img_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_ignores_rx: got %0d acks rdy=%b, expected 0 acks rdy=1", taken_cnt - t0, img_ready);
    end
    img_consumed = 1'b1;
    tick();
    img_consumed = 1'b0;
    tests++;
    if (img_ready !== 1'b0 || rx_enable !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL consume: got rdy=%b rx=%b busy=%b, expected 0 1 0", img_ready, rx_enable, busy);
    end
    tick();
    test_full_load(8'h80);
    img_consumed = 1'b1;
    tick();
    img_consumed = 1'b0;
    tick();
    tests++;
    if (img_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL consume2: got rdy=%b busy=%b, expected 0 0", img_ready, busy);
    end
  endtask

  task automatic test_bad_cmd_clear();
    int e0;
    int t0;
    int bad;
    e0 = err_cnt;
    t0 = taken_cnt;
    send_byte(8'h55);
    tests++;
    if (tk_taken !== 1'b1 || tk_err !== 1'b1 || err_cnt - e0 != 1 || busy !== 1'b0 || rx_enable !== 1'b1) begin
      fails++;
      $display("FAIL bad_cmd: got taken=%b err=%b pulses=%0d busy=%b rx=%b, expected 1 1 1 0 1",
               tk_taken, tk_err, err_cnt - e0, busy, rx_enable);
    end
    for (int k = 0; k < IMG_BYTES; k++) push_wr(k, 8'h00);
    send_byte(8'hC0);
    tests++;
    if (tk_taken !== 1'b1 || tk_rxen !== 1'b0 || tk_busy !== 1'b1) begin
      fails++;
      $display("FAIL clear_start: got taken=%b rx=%b busy=%b, expected 1 0 1", tk_taken, tk_rxen, tk_busy);
    end
    bad = 0;
    spi_rx_data = 8'hA0;
    byte_valid  = 1'b1;
    for (int i = 0; i < IMG_BYTES - 3; i++) begin
      if (i == IMG_BYTES - 4) byte_valid = 1'b0;
      tick();
      if (buf_we !== 1'b1 || rx_enable !== 1'b0 || busy !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL clear_stream: got %0d bad cycles, expected 0", bad);
    end
    tick();
    tests++;
    if (buf_we !== 1'b0 || busy !== 1'b0 || rx_enable !== 1'b1 || img_ready !== 1'b0) begin
      fails++;
      $display("FAIL clear_end: got we=%b busy=%b rx=%b rdy=%b, expected 0 0 1 0", buf_we, busy, rx_enable, img_ready);
    end
    tests++;
    if (exp_q.size() != 0 || taken_cnt - t0 != 2) begin
      fails++;
      $display("FAIL clear_counts: got %0d pending %0d acks, expected 0 and 2", exp_q.size(), taken_cnt - t0);
    end
  endtask

  task automatic test_timeout();
    int e0;
    int last;
    e0 = err_cnt;
    send_byte(8'hA0);
    for (int k = 0; k < 10; k++) begin
      push_wr(k, 8'h30 + 8'(k));
      send_byte(8'h30 + 8'(k));
    end
    last = tk_cyc;
    repeat (TMO + 10) tick();
    tests++;
    if (err_cnt - e0 != 1 || err_cyc - last != TMO) begin
      fails++;
      $display("FAIL timeout_timing: got %0d pulses at +%0d, expected 1 at +%0d", err_cnt - e0, err_cyc - last, TMO);
    end
    tests++;
    if (img_ready !== 1'b0 || rx_enable !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL timeout_state: got rdy=%b rx=%b busy=%b pending=%0d, expected 0 1 0 0",
               img_ready, rx_enable, busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    send_byte(8'hA0);
    for (int k = 0; k < 40; k++) begin
      push_wr(k, 8'hF0 - 8'(k));
      send_byte(8'hF0 - 8'(k));
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if ({byte_taken, rx_enable, buf_we, img_ready, cmd_error, busy, buf_addr} !== '0) begin
      fails++;
      $display("FAIL mid_reset: got rx=%b we=%b rdy=%b busy=%b addr=%0d, expected all 0",
               rx_enable, buf_we, img_ready, busy, buf_addr);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (rx_enable !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_release: got rx=%b busy=%b, expected 1 0", rx_enable, busy);
    end
    test_full_load(8'h00);
  endtask

  initial begin
    test_reset();
    test_full_load(8'h00);
    test_consume_reload();
    test_bad_cmd_clear();
    test_timeout();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
